memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Single-port memory arbiter between the datapath's instruction-fetch and data-access request strobes and the unified RAM. It accepts the `iREN` request and the `dREN`/`dWEN` requests from the request unit. It serialises them onto one RAM port and returns one-cycle `ihit`/`dhit` completions with load data. It also enforces a bus timeout and records a sticky error flag.

## Interface
- `TIMEOUT`, default 16: maximum cycles an access may wait for `ACCESS` before forced completion; legal range is 2–255.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in 1: instruction read request.
- `iaddr` in 32: instruction address.
- `iload` out 32: instruction read data.
- `ihit` out 1: instruction access complete, one-cycle pulse.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: data write value.
- `dload` out 32: data read data.
- `dhit` out 1: data access complete, one-cycle pulse.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status. FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `busy` out 1: an access is in flight.
- `memerr` out 1: sticky error; set on ERROR or timeout, cleared only by reset.

## Operation
**States.** The arbiter has three states: `IDLE`, `DACC` and `IACC`.

**Arbitration in `IDLE`:**
- Any data request (`dREN | dWEN`) wins over `iREN`.
- Exception: if the previous grant was data (flag `last_d` = 1) and `iREN` is high, the grant goes to instruction. This prevents fetch starvation.
- On a data grant: latch `daddr` into `ramaddr` and `dstore` into `ramstore`. Latch the op as write if `dWEN`, else read; `dWEN` wins when both are high. Go to `DACC` and set `last_d` = 1.
- On an instruction grant: latch `iaddr` into `ramaddr` and go to `IACC`. Set `last_d` = 0.
- With no request, stay in `IDLE`.

**Strobes.** Strobes are Moore outputs:
- `DACC` read: `ramREN` = 1.
- `DACC` write: `ramWEN` = 1.
- `IACC`: `ramREN` = 1.
- `IDLE`: both strobes 0. `ramREN` and `ramWEN` are never high together.

**Completion in `DACC`/`IACC`.** An access completes in the cycle in which either:
- `ramstate` == ACCESS, or
- `ramstate` == ERROR, or
- the wait counter == `TIMEOUT`-1 (timeout).

On completion:
- The matching hit (`dhit` or `ihit`) is high combinationally for that one cycle.
- The state returns to `IDLE` at the next edge.
- The wait counter clears.

**Wait counter.** It is 8 bits, increments each cycle spent in `DACC`/`IACC` without completion, and is 0 in `IDLE`.

**Load data:**
- During a read hit with ACCESS, `dload`/`iload` = `ramload` (passthrough). The value is captured at that edge and held afterwards.
- On ERROR or timeout, the load output is driven to 0 and 0 is captured.
- Write completions leave `dload` unchanged.

**Error and busy flags:**
- ERROR or timeout completion sets `memerr` at the edge.
- `busy` = 1 in `DACC`/`IACC`.

**Latched requests.** Requests are latched at grant. Dropping or changing the request, address or store data mid-access has no effect, and the hit still pulses.

**Reset.** Reset at any time, including mid-access, forces `IDLE` immediately. All outputs go to 0: `ramREN`, `ramWEN`, `ramaddr`, `ramstore`, `iload`, `dload`, `ihit`, `dhit`, `busy` and `memerr`. `last_d` = 0 and the counter = 0.

## Timing
- **Grant.** A request that is high at edge N in `IDLE` gives strobes and `ramaddr` valid from edge N.
- **Minimum latency.** If the RAM returns ACCESS in the first cycle, the hit occurs in that same cycle, one cycle after the request is sampled.
- **Bubble.** There is one mandatory `IDLE` cycle between consecutive accesses. The best-case back-to-back throughput is one access per 2 cycles.
- **Hit width.** Hits are exactly one cycle and are never asserted in `IDLE`. `ihit` and `dhit` are never high together.
- **Request release.** After `dhit`, the requester must deassert `dREN`/`dWEN` by the following edge; otherwise a new data access is arbitrated. In that case `last_d` = 1, so a pending `iREN` wins first.
- **Timeout.** The worst case is `TIMEOUT` cycles in an access state. Completion occurs in the `TIMEOUT`-th cycle.

## Test plan
- **Reset mid-access.** Assert `nRST`=0 during `DACC` with `ramWEN`=1 → in the same cycle all outputs are 0. After release, the state is `IDLE` with `busy`=0.
- **Instruction fetch.** `iREN`=1, `iaddr`=0x00000040, RAM returns ACCESS after 3 BUSY cycles with `ramload`=0x8C220004 → `ramREN` high for 4 cycles, `ihit` for 1 cycle, `iload`=0x8C220004 held afterwards.
- **Simultaneous requests.** `iREN`=1 and `dWEN`=1 (`daddr`=0x100, `dstore`=0xDEADBEEF), RAM always ACCESS → data write is granted first and `dhit` pulses. The next grant is instruction even though the data request stays asserted, then data again (alternation).
- **Both data strobes.** `dREN`=`dWEN`=1 → a write occurs: `ramWEN`=1, `ramREN`=0.
- **ERROR completion.** `ramstate`=ERROR on a data read → `dhit` for 1 cycle, `dload`=0, `memerr`=1, which stays 1 through later successful accesses until reset.
- **Timeout.** `TIMEOUT`=4, RAM stuck BUSY on a fetch → `ihit` in the 4th access cycle, `iload`=0, `memerr`=1, then the state returns to `IDLE`.

Source files
------------

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access, with bus timeout and sticky error.
// Strobes are registered at grant and hits are combinational on completion; one IDLE bubble separates accesses.
module memory_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        busy,
  output logic        memerr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        memerr_q, memerr_d;

  logic        in_acc;
  logic        acc_ok;
  logic        done;
  logic        dreq;
  logic        grant_i;
  logic        grant_d;
  logic        ihit_c;
  logic        dhit_c;
  logic [31:0] rd_data;

  always_comb begin
    in_acc  = (state_q == DACC) || (state_q == IACC);
    acc_ok  = (ramstate == RAM_ACCESS);
    done    = in_acc && (acc_ok || (ramstate == RAM_ERROR) || (cnt_q == CNT_LAST));
    dreq    = dREN | dWEN;
    // A fetch wins after a data grant so a streaming data requester cannot starve it.
    grant_i = iREN && (!dreq || last_d_q);
    grant_d = dreq && !grant_i;
    ihit_c  = (state_q == IACC) && done;
    dhit_c  = (state_q == DACC) && done;
    // Errored or timed-out reads return zero rather than whatever is on the bus.
    rd_data = acc_ok ? ramload : 32'd0;

    state_d  = state_q;
    last_d_d = last_d_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    store_d  = store_q;
    memerr_d = memerr_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (grant_i) begin
          addr_d   = iaddr;
          state_d  = IACC;
          last_d_d = 1'b0;
        end else if (grant_d) begin
          addr_d   = daddr;
          store_d  = dstore;
          wr_d     = dWEN;
          state_d  = DACC;
          last_d_d = 1'b1;
        end
      end
      DACC, IACC: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          if (!acc_ok) memerr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    iload_d = ihit_c ? rd_data : iload_q;
    dload_d = (dhit_c && !wr_q) ? rd_data : dload_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      store_q  <= 32'd0;
      iload_q  <= 32'd0;
      dload_q  <= 32'd0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      memerr_q <= memerr_d;
    end
  end

  assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
  assign ramWEN   = (state_q == DACC) && wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = ihit_c;
  assign dhit     = dhit_c;
  assign iload    = iload_d;
  assign dload    = dload_d;
  assign busy     = in_acc;
  assign memerr   = memerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at default TIMEOUT, one at TIMEOUT=4 for the timeout case.
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;

  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, busy, memerr;

  logic [31:0] iload4, dload4, ramaddr4, ramstore4;
  logic        ihit4, dhit4, ramREN4, ramWEN4, busy4, memerr4;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  memory_arbiter u_dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .busy(busy), .memerr(memerr)
  );

  memory_arbiter #(.TIMEOUT(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload4), .ihit(ihit4),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload4), .dhit(dhit4),
    .ramREN(ramREN4), .ramWEN(ramWEN4), .ramaddr(ramaddr4), .ramstore(ramstore4),
    .ramload(ramload), .ramstate(ramstate), .busy(busy4), .memerr(memerr4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    int hit_cycle;
    nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = FREE;
    #1 nRST = 1'b0;
    #2;
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_memerr", {31'd0, memerr}, 32'd0);
    cyc();
    nRST = 1'b1;
    cyc();

    // Instruction fetch: three BUSY cycles, then ACCESS.
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = BUSY; settle();
    chk("if_idle_ramREN", {31'd0, ramREN}, 32'd0);
    cyc();
    iREN = 1'b0; iaddr = 32'h0000_0999; settle();
    chk("if_c1_ramREN", {31'd0, ramREN}, 32'd1);
    chk("if_c1_ramaddr", ramaddr, 32'h0000_0040);
    chk("if_c1_busy", {31'd0, busy}, 32'd1);
    chk("if_c1_ihit", {31'd0, ihit}, 32'd0);
    cyc();
    chk("if_c2_ramREN", {31'd0, ramREN}, 32'd1);
    chk("if_c2_ihit", {31'd0, ihit}, 32'd0);
    cyc();
    chk("if_c3_ramREN", {31'd0, ramREN}, 32'd1);
    chk("if_c3_ihit", {31'd0, ihit}, 32'd0);
    cyc();
    ramstate = ACCESS; ramload = 32'h8C22_0004; settle();
    chk("if_c4_ramREN", {31'd0, ramREN}, 32'd1);
    chk("if_c4_ihit", {31'd0, ihit}, 32'd1);
    chk("if_c4_dhit", {31'd0, dhit}, 32'd0);
    chk("if_c4_iload", iload, 32'h8C22_0004);
    cyc();
    ramstate = FREE; ramload = 32'd0; settle();
    chk("if_after_ihit", {31'd0, ihit}, 32'd0);
    chk("if_after_ramREN", {31'd0, ramREN}, 32'd0);
    chk("if_after_busy", {31'd0, busy}, 32'd0);
    chk("if_after_iload", iload, 32'h8C22_0004);
    chk("if_after_memerr", {31'd0, memerr}, 32'd0);

    // Simultaneous fetch and data write: data first, then alternation.
    iREN = 1'b1; iaddr = 32'h0000_0080; dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    cyc();
    chk("sim_d_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("sim_d_ramREN", {31'd0, ramREN}, 32'd0);
    chk("sim_d_ramaddr", ramaddr, 32'h0000_0100);
    chk("sim_d_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("sim_d_dhit", {31'd0, dhit}, 32'd1);
    chk("sim_d_ihit", {31'd0, ihit}, 32'd0);
    cyc();
    chk("sim_bubble1_busy", {31'd0, busy}, 32'd0);
    chk("sim_bubble1_dhit", {31'd0, dhit}, 32'd0);
    cyc();
    chk("sim_i_ramREN", {31'd0, ramREN}, 32'd1);
    chk("sim_i_ramaddr", ramaddr, 32'h0000_0080);
    chk("sim_i_ihit", {31'd0, ihit}, 32'd1);
    chk("sim_i_dhit", {31'd0, dhit}, 32'd0);
    chk("sim_i_iload", iload, 32'h0BAD_F00D);
    cyc();
    chk("sim_bubble2_busy", {31'd0, busy}, 32'd0);
    cyc();
    iREN = 1'b0; dWEN = 1'b0; settle();
    chk("sim_d2_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("sim_d2_ramaddr", ramaddr, 32'h0000_0100);
    chk("sim_d2_dhit", {31'd0, dhit}, 32'd1);
    chk("sim_d2_dload", dload, 32'd0);
    cyc();
    chk("sim_end_busy", {31'd0, busy}, 32'd0);

    // Both data strobes: write takes precedence.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'h1234_5678;
    cyc();
    dREN = 1'b0; dWEN = 1'b0; settle();
    chk("both_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("both_ramREN", {31'd0, ramREN}, 32'd0);
    chk("both_ramstore", ramstore, 32'h1234_5678);
    chk("both_dload", dload, 32'd0);
    cyc();

    // Successful data read with passthrough and hold.
    dREN = 1'b1; daddr = 32'h0000_0300; ramload = 32'hCAFE_F00D;
    cyc();
    dREN = 1'b0; settle();
    chk("rd_ramREN", {31'd0, ramREN}, 32'd1);
    chk("rd_dhit", {31'd0, dhit}, 32'd1);
    chk("rd_dload", dload, 32'hCAFE_F00D);
    cyc();
    ramload = 32'h0; settle();
    chk("rd_hold_dload", dload, 32'hCAFE_F00D);

    // ERROR completion on a data read.
    dREN = 1'b1; daddr = 32'h0000_0304; ramstate = ERROR; ramload = 32'h5555_5555;
    cyc();
    dREN = 1'b0; settle();
    chk("err_dhit", {31'd0, dhit}, 32'd1);
    chk("err_dload", dload, 32'd0);
    chk("err_memerr_pre", {31'd0, memerr}, 32'd0);
    cyc();
    ramstate = ACCESS; ramload = 32'h1111_1111; settle();
    chk("err_memerr", {31'd0, memerr}, 32'd1);
    chk("err_dhit_off", {31'd0, dhit}, 32'd0);
    chk("err_dload_hold", dload, 32'd0);
    iREN = 1'b1; iaddr = 32'h0000_0044;
    cyc();
    iREN = 1'b0; settle();
    chk("err_ok_ihit", {31'd0, ihit}, 32'd1);
    chk("err_ok_iload", iload, 32'h1111_1111);
    cyc();
    chk("err_sticky", {31'd0, memerr}, 32'd1);

    // Reset in the middle of a write access.
    dWEN = 1'b1; daddr = 32'h0000_0400; dstore = 32'hA5A5_A5A5; ramstate = BUSY;
    cyc();
    chk("mid_ramWEN", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0; settle();
    chk("mid_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("mid_rst_ramaddr", ramaddr, 32'd0);
    chk("mid_rst_ramstore", ramstore, 32'd0);
    chk("mid_rst_iload", iload, 32'd0);
    chk("mid_rst_dload", dload, 32'd0);
    chk("mid_rst_memerr", {31'd0, memerr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_dhit", {31'd0, dhit}, 32'd0);
    dWEN = 1'b0;
    cyc();
    nRST = 1'b1;
    cyc();
    chk("mid_post_busy", {31'd0, busy}, 32'd0);
    chk("mid_post_ramWEN", {31'd0, ramWEN}, 32'd0);

    // Timeout on a fetch with the RAM stuck BUSY.
    iREN = 1'b1; iaddr = 32'h0000_0500; ramload = 32'hFFFF_FFFF;
    cyc();
    iREN = 1'b0; settle();
    chk("to4_c1_busy", {31'd0, busy4}, 32'd1);
    chk("to4_c1_ihit", {31'd0, ihit4}, 32'd0);
    cyc();
    chk("to4_c2_ihit", {31'd0, ihit4}, 32'd0);
    cyc();
    chk("to4_c3_ihit", {31'd0, ihit4}, 32'd0);
    cyc();
    chk("to4_c4_ihit", {31'd0, ihit4}, 32'd1);
    chk("to4_c4_iload", iload4, 32'd0);
    chk("to4_c4_memerr_pre", {31'd0, memerr4}, 32'd0);
    chk("to16_c4_ihit", {31'd0, ihit}, 32'd0);
    cyc();
    chk("to4_idle_busy", {31'd0, busy4}, 32'd0);
    chk("to4_idle_ihit", {31'd0, ihit4}, 32'd0);
    chk("to4_memerr", {31'd0, memerr4}, 32'd1);
    chk("to4_iload_hold", iload4, 32'd0);
    // Default-TIMEOUT instance keeps waiting until its 16th access cycle.
    hit_cycle = 0;
    for (int c = 5; c <= 24; c++) begin
      if (ihit && hit_cycle == 0) hit_cycle = c;
      if (hit_cycle == 0) cyc();
    end
    chk("to16_hit_cycle", hit_cycle, 32'd16);
    chk("to16_iload", iload, 32'd0);
    cyc();
    chk("to16_memerr", {31'd0, memerr}, 32'd1);
    chk("to16_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
